control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 11, program counter and operand width.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 5, opcode field width (instruction = OPCODE_WIDTH + PC_WIDTH = 16 bits).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr_addr  output  PC_WIDTH  program memory address, equal to the PC.
REQ-006 SHALL have port instruction  input  16  program memory data: [15:11] opcode, [10:0] operand; valid one cycle after instr_addr is stable.
REQ-007 SHALL have port operand  output  PC_WIDTH  immediate value or data address for the datapath.
REQ-008 SHALL have port sel_a  output  2  accumulator source: 00 data memory, 01 immediate operand, 10 ALU result.
REQ-009 SHALL have port sel_b  output  1  ALU B source: 0 data memory, 1 immediate operand.
REQ-010 SHALL have port wr_acc  output  1  accumulator write enable.
REQ-011 SHALL have port op  output  1  ALU operation: 0 add, 1 subtract.
REQ-012 SHALL have ports wr_ram and rd_ram  output  1 each  data memory write and read strobes.
REQ-013 SHALL have port halted  output  1  high while in HALT.
REQ-014 SHALL have port cycle_count  output  16  count of clock cycles since reset release, excluding HALT cycles.

Function
REQ-015 SHALL implement FSM states FETCH, EXEC and HALT.
- FETCH -> EXEC unconditionally.
- EXEC -> HALT on HLT.
- EXEC -> FETCH otherwise.
- HALT is sticky until reset.
REQ-016 In FETCH, SHALL drive instr_addr = PC, with operand, sel_a, sel_b, wr_acc, op, wr_ram and rd_ram all 0.
REQ-017 In EXEC, SHALL decode the control outputs combinationally from instruction, and SHALL drive operand = instruction[10:0].
REQ-018 SHALL use this decode table (all unlisted outputs 0):
- HLT 00000: none.
- STO 00001: wr_ram.
- LD 00010: rd_ram, sel_a=00, wr_acc.
- LDI 00011: sel_a=01, wr_acc.
- ADD 00100: rd_ram, sel_a=10, sel_b=0, op=0, wr_acc.
- ADDI 00101: sel_a=10, sel_b=1, op=0, wr_acc.
- SUB 00110: as ADD with op=1.
- SUBI 00111: as ADDI with op=1.
REQ-019 SHALL treat opcodes 01000-11111 as NOP: no enables asserted, PC advances.
REQ-020 SHALL increment PC by 1 at the end of each non-HLT EXEC cycle; each instruction takes exactly 2 cycles.
REQ-021 SHALL wrap PC from 2^PC_WIDTH-1 to 0 without any flag.
REQ-022 On HLT, SHALL hold PC at the HLT address, and in HALT SHALL hold all enables at 0 and halted at 1.
REQ-023 SHALL increment cycle_count in FETCH and EXEC, and SHALL wrap cycle_count from 0xFFFF to 0.

Reset
REQ-024 When reset=0, SHALL immediately force state FETCH, PC=0, cycle_count=0 and halted=0, independent of clk.
REQ-025 While reset=0, SHALL hold every control output at 0 and instr_addr at 0.
REQ-026 Reset asserted mid-EXEC or in HALT SHALL abort the instruction; no enable may glitch high after reset falls.
REQ-027 After reset rises, the first rising clk edge SHALL begin EXEC of address 0.

Structure
REQ-028 SHALL place opcode constants, sel_a encodings, FSM state encoding and PC_WIDTH/OPCODE_WIDTH defaults in shared package bip_pkg, also used by the datapath.
REQ-029 SHALL implement the decode table as one combinational sub-module, instr_decoder; the PC, FSM and counter remain in control_unit.

Verification
REQ-030 Reset check: hold reset=0 for 3 cycles, toggling clk -> instr_addr=0, all enables 0, halted=0, cycle_count=0.
REQ-031 Program check: program 0x1805, 0x2803, 0x080A, 0x0000 ->
- EXEC outputs in order: (sel_a=01, wr_acc, operand=5); (sel_a=10, sel_b=1, op=0, wr_acc, operand=3); (wr_ram, operand=10); (none).
- instr_addr sequence 0,1,2,3.
- halted=1 from cycle 8 with instr_addr held at 3 and cycle_count frozen at 8.
REQ-032 SUB check: instruction 0x3007 -> in EXEC rd_ram=1, sel_a=10, sel_b=0, op=1, wr_acc=1, operand=7.
REQ-033 Undefined opcode: 0xF8FF at address 0 -> no enables in EXEC, next instr_addr=1.
REQ-034 PC wrap: NOP at 2047 -> following FETCH presents instr_addr=0.
REQ-035 Mid-EXEC reset: assert reset=0 during the EXEC of 0x2803 -> wr_acc falls in the same cycle without a clk edge, PC=0 and cycle_count=0.

Source files
------------

// File: rtl/bip_pkg.sv
// bip_pkg: opcode, mux-select and FSM encodings shared by the control unit and datapath.
package bip_pkg;

    localparam int PC_WIDTH_DEF     = 11;
    localparam int OPCODE_WIDTH_DEF = 5;

    localparam logic [OPCODE_WIDTH_DEF-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPCODE_WIDTH_DEF-1:0] OP_STO  = 5'b00001;
    localparam logic [OPCODE_WIDTH_DEF-1:0] OP_LD   = 5'b00010;
    localparam logic [OPCODE_WIDTH_DEF-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPCODE_WIDTH_DEF-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPCODE_WIDTH_DEF-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPCODE_WIDTH_DEF-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPCODE_WIDTH_DEF-1:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SEL_A_MEM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       wr_acc;
        logic       op;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational opcode-to-control decode; undefined opcodes decode as NOP.
module instr_decoder
    import bip_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    output ctrl_t                   o_ctrl,
    output logic                    o_hlt
);

    always_comb begin
        o_ctrl = '0;
        o_hlt  = (i_opcode == OP_HLT);
        case (i_opcode)
            OP_STO: o_ctrl.wr_ram = 1'b1;
            OP_LD: begin
                o_ctrl.rd_ram = 1'b1;
                o_ctrl.sel_a  = SEL_A_MEM;
                o_ctrl.wr_acc = 1'b1;
            end
            OP_LDI: begin
                o_ctrl.sel_a  = SEL_A_IMM;
                o_ctrl.wr_acc = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                o_ctrl.rd_ram = 1'b1;
                o_ctrl.sel_a  = SEL_A_ALU;
                o_ctrl.wr_acc = 1'b1;
                o_ctrl.op     = (i_opcode == OP_SUB);
            end
            OP_ADDI, OP_SUBI: begin
                o_ctrl.sel_a  = SEL_A_ALU;
                o_ctrl.sel_b  = 1'b1;
                o_ctrl.wr_acc = 1'b1;
                o_ctrl.op     = (i_opcode == OP_SUBI);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: two-cycle FETCH/EXEC sequencer with PC, sticky HALT and active-cycle counter.
module control_unit
    import bip_pkg::*;
#(
    parameter int PC_WIDTH     = PC_WIDTH_DEF,
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic [PC_WIDTH-1:0]              instr_addr,
    input  logic [OPCODE_WIDTH+PC_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]              operand,
    output logic [1:0]                       sel_a,
    output logic                             sel_b,
    output logic                             wr_acc,
    output logic                             op,
    output logic                             wr_ram,
    output logic                             rd_ram,
    output logic                             halted,
    output logic [15:0]                      cycle_count
);

    state_e              r_state;
    state_e              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_cnt;
    ctrl_t               w_dec;
    logic                w_hlt;
    logic                w_exec;

    instr_decoder #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_dec (
        .i_opcode (instruction[OPCODE_WIDTH+PC_WIDTH-1:PC_WIDTH]),
        .o_ctrl   (w_dec),
        .o_hlt    (w_hlt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC && !w_hlt)
                r_pc <= r_pc + 1'b1;
            if (r_state != S_HALT)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == S_FETCH) ? S_EXEC :
                 (r_state == S_EXEC)  ? (w_hlt ? S_HALT : S_FETCH) : S_HALT;
    end

    // Gating with reset keeps every enable low the instant reset falls, regardless of state.
    assign w_exec      = reset && (r_state == S_EXEC);
    assign halted      = reset && (r_state == S_HALT);
    assign instr_addr  = r_pc;
    assign cycle_count = r_cnt;
    assign operand     = w_exec ? instruction[PC_WIDTH-1:0] : '0;
    assign {sel_a, sel_b, wr_acc, op, wr_ram, rd_ram} = w_exec ? w_dec : '0;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and random programs checked against an instruction-level model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] instr_addr;
    logic [15:0] instruction = '0;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b, wr_acc, op, wr_ram, rd_ram, halted;
    logic [15:0] cycle_count;

    logic [15:0] mem [2048];
    logic [6:0]  tab [32];
    logic [10:0] m_pc;
    logic [15:0] m_cnt;
    logic        m_halt;
    int          vecs = 0;
    int          errs = 0;

    wire [6:0] ctrl = {sel_a, sel_b, wr_acc, op, wr_ram, rd_ram};

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instr_addr  (instr_addr),
        .instruction (instruction),
        .operand     (operand),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .wr_acc      (wr_acc),
        .op          (op),
        .wr_ram      (wr_ram),
        .rd_ram      (rd_ram),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data valid one cycle after the address.
    always @(posedge clk) instruction <= mem[instr_addr];

    function automatic logic [6:0] pk(input logic [1:0] sa, input logic sb, input logic wa,
                                      input logic o, input logic wr, input logic rd);
        return {sa, sb, wa, o, wr, rd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_addr", 32'(instr_addr), 0);
            chk("rst_ctrl", 32'(ctrl), 0);
            chk("rst_operand", 32'(operand), 0);
            chk("rst_halted", 32'(halted), 0);
            chk("rst_count", 32'(cycle_count), 0);
        end
        reset  = 1'b1;
        m_pc   = '0;
        m_cnt  = '0;
        m_halt = 1'b0;
    endtask

    task automatic run_instr();
        logic [15:0] ins;
        ins = mem[m_pc];
        chk("fetch_addr", 32'(instr_addr), 32'(m_pc));
        chk("fetch_ctrl", 32'(ctrl), 0);
        chk("fetch_operand", 32'(operand), 0);
        chk("fetch_halted", 32'(halted), 0);
        chk("fetch_count", 32'(cycle_count), 32'(m_cnt));
        @(negedge clk);
        chk("exec_addr", 32'(instr_addr), 32'(m_pc));
        chk("exec_ctrl", 32'(ctrl), 32'(tab[ins[15:11]]));
        chk("exec_operand", 32'(operand), 32'(ins[10:0]));
        chk("exec_halted", 32'(halted), 0);
        chk("exec_count", 32'(cycle_count), 32'(m_cnt + 16'd1));
        @(negedge clk);
        m_cnt = m_cnt + 16'd2;
        if (ins[15:11] == 5'd0) m_halt = 1'b1;
        else m_pc = m_pc + 11'd1;
    endtask

    task automatic chk_halt(input int n);
        repeat (n) begin
            chk("halt_flag", 32'(halted), 1);
            chk("halt_addr", 32'(instr_addr), 32'(m_pc));
            chk("halt_ctrl", 32'(ctrl), 0);
            chk("halt_operand", 32'(operand), 0);
            chk("halt_count", 32'(cycle_count), 32'(m_cnt));
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        foreach (tab[i]) tab[i] = '0;
        tab[1] = pk(2'b00, 0, 0, 0, 1, 0);
        tab[2] = pk(2'b00, 0, 1, 0, 0, 1);
        tab[3] = pk(2'b01, 0, 1, 0, 0, 0);
        tab[4] = pk(2'b10, 0, 1, 0, 0, 1);
        tab[5] = pk(2'b10, 1, 1, 0, 0, 0);
        tab[6] = pk(2'b10, 0, 1, 1, 0, 1);
        tab[7] = pk(2'b10, 1, 1, 1, 0, 0);
        foreach (mem[i]) mem[i] = '0;

        // Directed program: LDI 5, ADDI 3, STO 10, HLT
        mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h080A; mem[3] = 16'h0000;
        do_reset();
        repeat (4) run_instr();
        chk("prog_halt_pc", 32'(m_pc), 3);
        chk("prog_halt_cnt8", 32'(cycle_count), 8);
        chk_halt(4);

        // Reset while halted clears halted immediately
        #2 reset = 1'b0;
        #1 chk("halt_rst_flag", 32'(halted), 0);
        chk("halt_rst_count", 32'(cycle_count), 0);

        // SUB from memory
        mem[0] = 16'h3007; mem[1] = 16'h0000;
        do_reset();
        repeat (2) run_instr();
        chk_halt(2);

        // Undefined opcode behaves as NOP
        mem[0] = 16'hF8FF; mem[1] = 16'h0000;
        do_reset();
        repeat (2) run_instr();
        chk("nop_pc", 32'(m_pc), 1);
        chk_halt(2);

        // Mid-EXEC reset during ADDI
        mem[0] = 16'h1805; mem[1] = 16'h2803;
        do_reset();
        run_instr();
        @(negedge clk);
        chk("mid_wr_acc_before", 32'(wr_acc), 1);
        #2 reset = 1'b0;
        #1 chk("mid_wr_acc_after", 32'(wr_acc), 0);
        chk("mid_ctrl", 32'(ctrl), 0);
        chk("mid_addr", 32'(instr_addr), 0);
        chk("mid_count", 32'(cycle_count), 0);
        chk("mid_halted", 32'(halted), 0);

        // PC wrap through a memory full of random NOPs
        foreach (mem[i]) mem[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
        do_reset();
        repeat (2049) run_instr();
        chk("wrap_pc", 32'(m_pc), 1);

        // Random programs until HLT or budget
        for (int k = 0; k < 4; k++) begin
            foreach (mem[i]) mem[i] = {5'($urandom_range(0, 31)), 11'($urandom)};
            mem[0][15:11] = 5'($urandom_range(1, 31));
            do_reset();
            for (int n = 0; n < 300 && !m_halt; n++) run_instr();
            if (m_halt) chk_halt(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
